// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: takes one word per input handshake and emits it one bit per output handshake.
// Latency: first bit is presented 1 cycle after the word is accepted; back-to-back words chain with no bubble.
// Backpressure: ser_ready=0 freezes the presented bit; in_ready is low while a word is in flight, except on the accepted last bit.
module piso_serializer #(
    parameter int N         = 7,
    parameter int LSB_FIRST = 1,
    parameter int FCW       = 8,
    localparam int IW       = (N > 0) ? $clog2(N + 1) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N:0]     in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           ser_out,
    output logic           ser_valid,
    input  logic           ser_ready,
    output logic           ser_last,
    output logic           busy,
    output logic [IW-1:0]  bit_idx,
    output logic [FCW-1:0] frame_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(N);

    state_t         state;
    logic [N:0]     sreg;
    logic [IW-1:0]  idx_q;
    logic [FCW-1:0] frame_q;
    logic           rdy_en;
    logic           shifting;
    logic           at_last;
    logic           accept;

    assign shifting  = (state == SHIFT);
    assign at_last   = shifting && (idx_q == LAST_IDX);
    assign accept    = in_valid && in_ready;

    // rdy_en keeps in_ready low during reset, since IDLE alone would raise it.
    // The ser_ready term makes in_ready combinational from the sink; this enables zero-bubble chaining.
    assign in_ready  = rdy_en && ((state == IDLE) || (at_last && ser_ready));

    assign ser_out   = (LSB_FIRST != 0) ? sreg[0] : sreg[N];
    assign ser_valid = shifting;
    assign busy      = shifting;
    assign ser_last  = at_last;
    assign bit_idx   = idx_q;
    assign frame_cnt = frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sreg    <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            rdy_en  <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg  <= in_data;
                        idx_q <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_ready) begin
                        if (idx_q == LAST_IDX) begin
                            frame_q <= frame_q + FCW'(1);
                            if (accept) begin
                                sreg  <= in_data;
                                idx_q <= '0;
                            end else begin
                                // After N+1 zero-filled shifts the register is empty, so ser_out idles at 0.
                                sreg  <= (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);
                                idx_q <= '0;
                                state <= IDLE;
                            end
                        end else begin
                            sreg  <= (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
